// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, decode redirect/hold controls and IF/ID outputs.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        jr;
   logic [31:0] jr_target;
   logic [31:0] instr_d;
   logic [31:0] pc4_d;
   logic        valid_d;
   logic        if_busy;

   modport master (
      output imem_addr, instr_d, pc4_d, valid_d, if_busy,
      input  imem_rdata, imem_ready, stall, br_taken, br_target,
             jump, jump_target, jr, jr_target
   );

   modport slave (
      input  imem_addr, instr_d, pc4_d, valid_d, if_busy,
      output imem_rdata, imem_ready, stall, br_taken, br_target,
             jump, jump_target, jr, jr_target
   );
endinterface

// File: rtl/fetch_stage.sv
// PC register plus IF/ID pipeline register; one-cycle fetch, holds whole stage when memory not ready or decode stalls.
// Macro DELAY_SLOT_EN keeps the instruction fetched alongside a redirect (MIPS delay slot); otherwise it is squashed.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_stage_if.master bus
);

   logic [31:0] pc_q,          pc_d;
   logic [31:0] ifid_instr_q,  ifid_instr_d;
   logic [31:0] ifid_pc4_q,    ifid_pc4_d;
   logic        ifid_valid_q,  ifid_valid_d;

   logic        advance;
   logic        redirect;
   logic [31:0] pc_plus4;
   logic [31:0] target;

   assign advance  = bus.imem_ready & ~bus.stall;
   assign redirect = bus.jr | bus.jump | bus.br_taken;
   assign pc_plus4 = pc_q + 32'd4;

   // jr wins over jump, jump over branch
   always_comb begin
      target = bus.br_target;
      if (bus.jr) begin
         target = bus.jr_target;
      end else if (bus.jump) begin
         target = bus.jump_target;
      end
   end

   always_comb begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      if (advance) begin
         pc_d         = redirect ? target : pc_plus4;
         ifid_pc4_d   = pc_plus4;
         ifid_instr_d = bus.imem_rdata;
         ifid_valid_d = 1'b1;
`ifndef DELAY_SLOT_EN
         if (redirect) begin
            ifid_instr_d = 32'h0;
            ifid_valid_d = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= 32'h0;
         ifid_pc4_q   <= 32'h0;
         ifid_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign bus.imem_addr = pc_q;
   assign bus.instr_d   = ifid_instr_q;
   assign bus.pc4_d     = ifid_pc4_q;
   assign bus.valid_d   = ifid_valid_q;
   assign bus.if_busy   = ~bus.imem_ready;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the block's only clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port imem_addr  output  32  current fetch PC to instruction memory.
REQ-005 SHALL have port imem_rdata  input  32  instruction word returned combinationally for imem_addr.
REQ-006 SHALL have port imem_ready  input  1  imem_rdata valid this cycle.
REQ-007 SHALL have port stall  input  1  hazard hold request from decode.
REQ-008 SHALL have port br_taken  input  1  branch in decode resolved taken.
REQ-009 SHALL have port br_target  input  32  branch target address.
REQ-010 SHALL have port jump  input  1  j/jal in decode.
REQ-011 SHALL have port jump_target  input  32  j/jal target address.
REQ-012 SHALL have port jr  input  1  jr in decode.
REQ-013 SHALL have port jr_target  input  32  register-sourced jr target.
REQ-014 SHALL have port instr_d  output  32  IF/ID instruction; opcode [31:26] and funct [5:0] feed the decoder.
REQ-015 SHALL have port pc4_d  output  32  IF/ID PC+4, used for link and branch offset.
REQ-016 SHALL have port valid_d  output  1  IF/ID holds a real instruction.
REQ-017 SHALL have port if_busy  output  1  high while imem_ready is low; decode holds ID.

Function
REQ-018 SHALL drive imem_addr from the PC register only.
REQ-019 SHALL define advance = imem_ready & ~stall; PC and IF/ID update only on advance.
REQ-020 SHALL drive if_busy = ~imem_ready combinationally.
REQ-021 SHALL, on advance with no redirect, load PC <= PC+4, instr_d <= imem_rdata, pc4_d <= PC+4, valid_d <= 1.
REQ-022 SHALL define redirect = jr | jump | br_taken, with next-PC priority jr > jump > br_taken.
REQ-023 SHALL, on advance with redirect, load PC <= selected target; IF/ID loading depends on REQ-033/034.
REQ-024 SHALL ignore redirect inputs in cycles without advance; decode holds the redirect, which is taken on the first advance cycle.
REQ-025 SHALL, when advance is low, hold PC, instr_d, pc4_d and valid_d unchanged; no bubble is inserted.
REQ-026 SHALL compute PC+4 modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-027 SHALL load targets unmodified, with no alignment check.
REQ-028 SHALL make stall override redirect when both are high in the same cycle.

Reset
REQ-029 SHALL, on reset_n low, asynchronously set PC=RESET_PC, instr_d=0, pc4_d=0 and valid_d=0.
REQ-030 SHALL, on reset mid-stall or mid-redirect, discard all pending state; the first fetch after release is at RESET_PC.
REQ-031 SHALL make the first rising edge with reset_n high and advance high load instr_d from RESET_PC.
REQ-032 SHALL keep if_busy combinational, so it follows imem_ready during reset.

Configuration
REQ-033 SHALL, with DELAY_SLOT_EN defined, latch the PC+4 instruction fetched in the redirect cycle into IF/ID normally (valid_d=1), giving MIPS branch delay slot semantics.
REQ-034 SHALL, without DELAY_SLOT_EN, squash that fetch: instr_d <= 32'h0 (nop), valid_d <= 0, pc4_d <= PC+4.

Verification
REQ-035 SHALL cover reset then free run with imem_ready=1: imem_addr 0x3000, 0x3004, 0x3008; instr_d tracks imem_rdata one cycle later.
REQ-036 SHALL cover stall=1 for 3 cycles at PC 0x3008: PC and instr_d frozen; after release, PC goes 0x300C.
REQ-037 SHALL cover br_taken with target 0x3100 at PC 0x3010: next PC 0x3100; instr_d = word at 0x3010 with DELAY_SLOT_EN, else 0 with valid_d=0.
REQ-038 SHALL cover jr=1 (0x3200) and br_taken=1 (0x3100) together: PC goes 0x3200; with stall also high, PC is held.
REQ-039 SHALL cover imem_ready=0 for 2 cycles: if_busy=1 and state held; PC at 0xFFFF_FFFC advances to 0x0000_0000.
REQ-040 SHALL cover reset_n pulsed low mid-cycle during stall: outputs zero immediately; PC=0x3000 after release.
